// File: rtl/test_module_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : test_module_unpacker_pkg
// Purpose  : Shared types and constants for the word-to-byte unpacker.
// Revision : 1.0 - initial release
// ============================================================================
package test_module_unpacker_pkg;

  localparam int BYTE_W_DEF = 8;
  localparam int TAG_W_DEF  = 4;
  localparam int BYTE_CNT_W = 16;
  localparam int PAD_CNT_W  = 8;

  // Value the packer places in the unused low byte of a hi-only word
  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT_HI = 2'd1,
    EMIT_LO = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/test_module_unpacker_fifo.sv
`default_nettype none
// ============================================================================
// Module   : test_module_unpacker_fifo
// Purpose  : Small synchronous FIFO; pointers carry a wrap bit so full and
//            empty are distinguished without a separate counter.
// Revision : 1.0 - initial release
// ============================================================================
module test_module_unpacker_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  // A push into a full FIFO is refused even when a pop happens the same cycle
  assign w_push_ok = push && !full && !flush;
  assign w_pop_ok  = pop && !empty && !flush;
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush returns both pointers to the empty position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array; contents need no reset because empty gates every read
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/test_module_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : test_module_word_unpacker
// Purpose  : Buffers tagged 16-bit words and emits them as bytes, high byte
//            first, checking the zero-pad convention of hi-only words.
// Revision : 1.0 - initial release
// ============================================================================
module test_module_word_unpacker
  import test_module_unpacker_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 16,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WORD_W-1:0]     s_data,
  input  logic [TAG_W-1:0]      s_tag,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  mode_pair,
  input  logic                  flush,
  output logic [BYTE_W-1:0]     m_data,
  output logic [TAG_W-1:0]      m_tag,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic [PAD_CNT_W-1:0]  pad_err_count,
  output logic                  busy
);

  localparam int ENTRY_W = TAG_W + WORD_W;

  state_t               r_state, w_nxt_state;
  logic [BYTE_W-1:0]    r_m_data, w_nxt_data;
  logic [TAG_W-1:0]     r_m_tag, w_nxt_tag;
  logic                 r_m_last, w_nxt_last;
  logic                 r_m_valid, w_nxt_valid;
  logic                 r_mode, w_nxt_mode;
  logic [BYTE_W-1:0]    r_lo_byte, w_nxt_lo;
  logic [BYTE_CNT_W-1:0] r_byte_count;
  logic [PAD_CNT_W-1:0] r_pad_err;

  logic                 w_full, w_empty, w_push, w_load, w_hs, w_pad_hit;
  logic [ENTRY_W-1:0]   w_head;
  logic [WORD_W-1:0]    w_head_data;
  logic [TAG_W-1:0]     w_head_tag;

  assign w_push      = s_valid && !w_full && !flush;
  assign w_hs        = r_m_valid && m_ready;
  assign w_head_data = w_head[WORD_W-1:0];
  assign w_head_tag  = w_head[ENTRY_W-1 -: TAG_W];

  test_module_unpacker_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (w_push),
    .wdata   ({s_tag, s_data}),
    .pop     (w_load),
    .full    (w_full),
    .empty   (w_empty),
    .head    (w_head)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nxt_state;
  end

  // Next-state and output-stage decode; a load pops the head word
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_data  = r_m_data;
    w_nxt_tag   = r_m_tag;
    w_nxt_last  = r_m_last;
    w_nxt_valid = r_m_valid;
    w_nxt_mode  = r_mode;
    w_nxt_lo    = r_lo_byte;
    w_load      = 1'b0;
    w_pad_hit   = 1'b0;
    if (flush) begin
      w_nxt_state = IDLE;
      w_nxt_valid = 1'b0;
    end else begin
      case (r_state)
        IDLE: w_load = !w_empty;
        EMIT_HI: begin
          if (w_hs) begin
            if (r_mode) begin
              w_nxt_data  = r_lo_byte;
              w_nxt_last  = 1'b1;
              w_nxt_state = EMIT_LO;
            end else if (!w_empty) begin
              w_load = 1'b1;
            end else begin
              w_nxt_valid = 1'b0;
              w_nxt_state = IDLE;
            end
          end
        end
        EMIT_LO: begin
          if (w_hs) begin
            if (!w_empty) begin
              w_load = 1'b1;
            end else begin
              w_nxt_valid = 1'b0;
              w_nxt_state = IDLE;
            end
          end
        end
        default: begin
          w_nxt_valid = 1'b0;
          w_nxt_state = IDLE;
        end
      endcase
      if (w_load) begin
        w_nxt_data  = w_head_data[WORD_W-1 -: BYTE_W];
        w_nxt_lo    = w_head_data[BYTE_W-1:0];
        w_nxt_tag   = w_head_tag;
        w_nxt_valid = 1'b1;
        w_nxt_mode  = mode_pair;
        w_nxt_last  = !mode_pair;
        w_nxt_state = EMIT_HI;
        w_pad_hit   = !mode_pair && (w_head_data[BYTE_W-1:0] != BYTE_W'(PAD_BYTE));
      end
    end
  end

  // Output stage and latched word context
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_data  <= '0;
      r_m_tag   <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
      r_mode    <= 1'b0;
      r_lo_byte <= '0;
    end else begin
      r_m_data  <= w_nxt_data;
      r_m_tag   <= w_nxt_tag;
      r_m_last  <= w_nxt_last;
      r_m_valid <= w_nxt_valid;
      r_mode    <= w_nxt_mode;
      r_lo_byte <= w_nxt_lo;
    end
  end

  // Delivered-byte counter (wraps) and pad-error counter (saturates)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_count <= '0;
      r_pad_err    <= '0;
    end else begin
      if (w_hs) r_byte_count <= r_byte_count + 1'b1;
      if (w_pad_hit && (r_pad_err != {PAD_CNT_W{1'b1}})) r_pad_err <= r_pad_err + 1'b1;
    end
  end

  assign s_ready       = !w_full;
  assign m_data        = r_m_data;
  assign m_tag         = r_m_tag;
  assign m_last        = r_m_last;
  assign m_valid       = r_m_valid;
  assign byte_count    = r_byte_count;
  assign pad_err_count = r_pad_err;
  assign busy          = !w_empty || r_m_valid;

endmodule
`default_nettype wire

// File: tb/tb_test_module_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_module_word_unpacker
// Purpose  : Directed self-checking bench for the word-to-byte unpacker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_module_word_unpacker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] s_data = '0;
  logic [3:0]  s_tag = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        mode_pair = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  m_data;
  logic [3:0]  m_tag;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] byte_count;
  logic [7:0]  pad_err_count;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] q_data[$];
  logic [3:0] q_tag[$];
  logic       q_last[$];

  test_module_word_unpacker #(
    .DEPTH(DEPTH), .WORD_W(16), .BYTE_W(8), .TAG_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_tag(s_tag),
    .s_valid(s_valid), .s_ready(s_ready), .mode_pair(mode_pair), .flush(flush),
    .m_data(m_data), .m_tag(m_tag), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .byte_count(byte_count), .pad_err_count(pad_err_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every delivered byte, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_tag.push_back(m_tag);
      q_last.push_back(m_last);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete(); q_tag.delete(); q_last.delete();
  endtask

  task automatic push_word(input logic [15:0] d, input logic [3:0] t);
    int g;
    g = 0;
    s_data = d; s_tag = t; s_valid = 1'b1;
    while (!s_ready && g < 200) begin step(); g++; end
    if (!s_ready) begin
      n_total++;
      $display("FAIL push_timeout: s_ready got 0 want 1");
    end else begin
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int g;
    g = 0;
    while (busy && g < max_cyc) begin step(); g++; end
    if (busy) begin
      n_total++;
      $display("FAIL idle_timeout: busy got 1 want 0");
    end
  endtask

  task automatic stream_words(input int n, input logic [15:0] d);
    int sent, g;
    sent = 0; g = 0;
    s_data = d; s_tag = 4'h1; s_valid = 1'b1;
    while (sent < n && g < 4 * n + 100) begin
      if (s_ready) sent++;
      step(); g++;
    end
    s_valid = 1'b0;
    if (sent != n) begin
      n_total++;
      $display("FAIL stream_timeout: sent %0d want %0d", sent, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    n_total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %0h want 0", m_valid); else n_pass++;
    n_total++; if (m_data !== 8'h00) $display("FAIL rst_m_data: got %0h want 0", m_data); else n_pass++;
    n_total++; if (m_tag !== 4'h0) $display("FAIL rst_m_tag: got %0h want 0", m_tag); else n_pass++;
    n_total++; if (m_last !== 1'b0) $display("FAIL rst_m_last: got %0h want 0", m_last); else n_pass++;
    n_total++; if (byte_count !== 16'h0) $display("FAIL rst_byte_count: got %0h want 0", byte_count); else n_pass++;
    n_total++; if (pad_err_count !== 8'h0) $display("FAIL rst_pad_err: got %0h want 0", pad_err_count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0h want 0", busy); else n_pass++;
    reset_n = 1'b1;
    step();
    n_total++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready: got %0h want 1", s_ready); else n_pass++;
  endtask

  task automatic test_pair_mode();
    clear_q();
    mode_pair = 1'b1; m_ready = 1'b1;
    push_word(16'hA53C, 4'h7);
    n_total++; if (m_valid !== 1'b0) $display("FAIL pair_latency_early: m_valid got %0h want 0", m_valid); else n_pass++;
    step();
    n_total++; if (m_valid !== 1'b1) $display("FAIL pair_latency: m_valid got %0h want 1", m_valid); else n_pass++;
    wait_idle(20);
    n_total++; if (q_data.size() != 2) $display("FAIL pair_nbytes: got %0d want 2", q_data.size()); else n_pass++;
    if (q_data.size() == 2) begin
      n_total++; if (q_data[0] !== 8'hA5 || q_last[0] !== 1'b0 || q_tag[0] !== 4'h7)
        $display("FAIL pair_byte0: got %0h/%0h/%0h want a5/0/7", q_data[0], q_last[0], q_tag[0]); else n_pass++;
      n_total++; if (q_data[1] !== 8'h3C || q_last[1] !== 1'b1 || q_tag[1] !== 4'h7)
        $display("FAIL pair_byte1: got %0h/%0h/%0h want 3c/1/7", q_data[1], q_last[1], q_tag[1]); else n_pass++;
    end
    n_total++; if (byte_count !== 16'd2) $display("FAIL pair_byte_count: got %0d want 2", byte_count); else n_pass++;
    n_total++; if (pad_err_count !== 8'd0) $display("FAIL pair_pad_err: got %0d want 0", pad_err_count); else n_pass++;
  endtask

  task automatic test_hi_only();
    clear_q();
    mode_pair = 1'b0; m_ready = 1'b1;
    push_word(16'h1200, 4'h2);
    push_word(16'h3401, 4'h3);
    wait_idle(20);
    n_total++; if (q_data.size() != 2) $display("FAIL hi_nbytes: got %0d want 2", q_data.size()); else n_pass++;
    if (q_data.size() == 2) begin
      n_total++; if (q_data[0] !== 8'h12 || q_last[0] !== 1'b1 || q_tag[0] !== 4'h2)
        $display("FAIL hi_byte0: got %0h/%0h/%0h want 12/1/2", q_data[0], q_last[0], q_tag[0]); else n_pass++;
      n_total++; if (q_data[1] !== 8'h34 || q_last[1] !== 1'b1 || q_tag[1] !== 4'h3)
        $display("FAIL hi_byte1: got %0h/%0h/%0h want 34/1/3", q_data[1], q_last[1], q_tag[1]); else n_pass++;
    end
    n_total++; if (pad_err_count !== 8'd1) $display("FAIL hi_pad_err: got %0d want 1", pad_err_count); else n_pass++;
    n_total++; if (byte_count !== 16'd4) $display("FAIL hi_byte_count: got %0d want 4", byte_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    mode_pair = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = {8'(2 * i + 1), 8'(2 * i + 2)};
      push_word(w, 4'(i + 1));
    end
    n_total++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready_full: got %0h want 0", s_ready); else n_pass++;
    s_data = 16'hFFFF; s_tag = 4'hF; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (m_valid !== 1'b1 || m_data !== 8'h01)
        $display("FAIL bp_hold: got %0h/%0h want 1/01", m_valid, m_data); else n_pass++;
      n_total++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready_hold: got %0h want 0", s_ready); else n_pass++;
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 2 * (DEPTH + 1); i++) begin
      n_total++;
      if (m_valid !== 1'b1 || m_data !== 8'(i + 1) || m_last !== 1'(i % 2) || m_tag !== 4'(i / 2 + 1))
        $display("FAIL bp_stream_%0d: got v%0h d%0h l%0h t%0h want v1 d%0h l%0h t%0h",
                 i, m_valid, m_data, m_last, m_tag, 8'(i + 1), 1'(i % 2), 4'(i / 2 + 1));
      else n_pass++;
      step();
    end
    n_total++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_drain: got v%0h b%0h want 0/0", m_valid, busy); else n_pass++;
    n_total++; if (byte_count !== 16'd14) $display("FAIL bp_byte_count: got %0d want 14", byte_count); else n_pass++;
  endtask

  task automatic test_count_wrap();
    mode_pair = 1'b1; m_ready = 1'b1;
    stream_words(32760, 16'h5A5A);
    wait_idle(20);
    n_total++; if (byte_count !== 16'hFFFE) $display("FAIL wrap_pre: got %0h want fffe", byte_count); else n_pass++;
    stream_words(1, 16'h5A5A);
    wait_idle(20);
    n_total++; if (byte_count !== 16'h0000) $display("FAIL wrap_zero: got %0h want 0", byte_count); else n_pass++;
  endtask

  task automatic test_pad_saturate();
    mode_pair = 1'b0; m_ready = 1'b1;
    stream_words(253, 16'h55AA);
    wait_idle(20);
    n_total++; if (pad_err_count !== 8'd254) $display("FAIL pad_254: got %0d want 254", pad_err_count); else n_pass++;
    stream_words(47, 16'h55AA);
    wait_idle(20);
    n_total++; if (pad_err_count !== 8'd255) $display("FAIL pad_sat: got %0d want 255", pad_err_count); else n_pass++;
    n_total++; if (byte_count !== 16'd300) $display("FAIL pad_byte_count: got %0d want 300", byte_count); else n_pass++;
  endtask

  task automatic test_flush();
    mode_pair = 1'b1; m_ready = 1'b0;
    push_word(16'hC0DE, 4'h4);
    push_word(16'h1111, 4'h5);
    push_word(16'h2222, 4'h6);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_total++; if (m_valid !== 1'b1 || m_data !== 8'hDE || m_last !== 1'b1)
      $display("FAIL flush_setup: got v%0h d%0h l%0h want 1/de/1", m_valid, m_data, m_last); else n_pass++;
    n_total++; if (byte_count !== 16'd301) $display("FAIL flush_pre_count: got %0d want 301", byte_count); else n_pass++;
    flush = 1'b1; s_data = 16'h7777; s_tag = 4'hE; s_valid = 1'b1;
    n_total++; if (s_ready !== 1'b1) $display("FAIL flush_s_ready: got %0h want 1", s_ready); else n_pass++;
    step();
    flush = 1'b0; s_valid = 1'b0;
    n_total++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL flush_clear: got v%0h b%0h want 0/0", m_valid, busy); else n_pass++;
    n_total++; if (byte_count !== 16'd301 || pad_err_count !== 8'd255)
      $display("FAIL flush_counters: got %0d/%0d want 301/255", byte_count, pad_err_count); else n_pass++;
    step(); step();
    n_total++; if (m_valid !== 1'b0) $display("FAIL flush_drop: m_valid got %0h want 0", m_valid); else n_pass++;
    clear_q();
    m_ready = 1'b1;
    push_word(16'h9876, 4'h6);
    wait_idle(20);
    n_total++; if (q_data.size() != 2) $display("FAIL flush_post_n: got %0d want 2", q_data.size()); else n_pass++;
    if (q_data.size() == 2) begin
      n_total++; if (q_data[0] !== 8'h98 || q_data[1] !== 8'h76 || q_tag[1] !== 4'h6)
        $display("FAIL flush_post_bytes: got %0h %0h t%0h want 98 76 t6", q_data[0], q_data[1], q_tag[1]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    mode_pair = 1'b1; m_ready = 1'b0;
    push_word(16'hAAAA, 4'hA);
    push_word(16'hBBBB, 4'hB);
    reset_n = 1'b0;
    #1;
    n_total++; if (m_valid !== 1'b0 || m_data !== 8'h00 || m_tag !== 4'h0 || m_last !== 1'b0)
      $display("FAIL rmid_outputs: got v%0h d%0h t%0h l%0h want 0", m_valid, m_data, m_tag, m_last); else n_pass++;
    n_total++; if (byte_count !== 16'h0 || pad_err_count !== 8'h0 || busy !== 1'b0)
      $display("FAIL rmid_counters: got %0h/%0h b%0h want 0", byte_count, pad_err_count, busy); else n_pass++;
    step();
    reset_n = 1'b1;
    step();
    clear_q();
    m_ready = 1'b1;
    push_word(16'hBEEF, 4'h9);
    wait_idle(20);
    n_total++; if (q_data.size() != 2) $display("FAIL rmid_post_n: got %0d want 2", q_data.size()); else n_pass++;
    if (q_data.size() == 2) begin
      n_total++; if (q_data[0] !== 8'hBE || q_data[1] !== 8'hEF || q_last[0] !== 1'b0 || q_last[1] !== 1'b1 || q_tag[0] !== 4'h9)
        $display("FAIL rmid_post_bytes: got %0h %0h l%0h%0h t%0h want be ef l01 t9",
                 q_data[0], q_data[1], q_last[0], q_last[1], q_tag[0]); else n_pass++;
    end
    n_total++; if (byte_count !== 16'd2) $display("FAIL rmid_byte_count: got %0d want 2", byte_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pair_mode();
    test_hi_only();
    test_back_to_back();
    test_count_wrap();
    test_pad_saturate();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/test_module_word_unpacker.md
Name: test_module_word_unpacker

Overview:
- Receive-side counterpart of the team's byte-to-word packer.
- Accepts 16-bit words plus a 4-bit control tag over a valid/ready slave interface and buffers them in a small FIFO.
- Emits bytes, high byte first, over a valid/ready master interface.
- Sits between the packer's data_out/status/valid/ready outputs and any byte-wide consumer.
- Checks the packer's zero-pad convention and counts pad violations.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- WORD_W, 16, input word width; fixed at 2×BYTE_W.
- BYTE_W, 8, output byte width.
- TAG_W, 4, control/status tag width carried with each word.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_data  input  WORD_W  incoming word; high byte is [15:8].
- s_tag  input  TAG_W  control tag for the word.
- s_valid  input  1  word present.
- s_ready  output  1  unpacker can accept a word.
- mode_pair  input  1  1 = emit both bytes; 0 = emit high byte only and check that the low byte is 8'h00.
- flush  input  1  synchronous clear of the FIFO and the output stage.
- m_data  output  BYTE_W  outgoing byte.
- m_tag  output  TAG_W  tag of the word the byte came from.
- m_last  output  1  byte is the final byte of its word.
- m_valid  output  1  byte present.
- m_ready  input  1  consumer accepts the byte.
- byte_count  output  16  bytes delivered; wraps modulo 2^16.
- pad_err_count  output  8  hi-only words whose low byte was nonzero; saturates at 255.
- busy  output  1  FIFO not empty or m_valid high.

Behaviour:
- Reset, asynchronous on reset_n low:
  - FIFO empty; state IDLE.
  - m_valid=0, m_data=0, m_tag=0, m_last=0.
  - byte_count=0, pad_err_count=0.
  - s_ready=1 one cycle after reset_n deasserts.
  - A reset mid-word discards the word silently.
- Slave side:
  - s_ready = !fifo_full, driven from registered FIFO state only; no combinational path from m_ready.
  - A push occurs when s_valid && s_ready.
  - When full, no push occurs even if a pop happens in the same cycle.
- Handshakes:
  - A byte transfers on m_valid && m_ready.
  - While m_valid && !m_ready, m_data, m_tag and m_last hold stable.
  - m_ready while m_valid=0 is ignored.
- FSM states: IDLE, EMIT_HI, EMIT_LO.
- Word load (a "load" occurs when the FIFO is non-empty and the current state permits it):
  - Pop the head word.
  - m_data = word[15:8], m_tag = tag, m_valid = 1.
  - Latch mode_pair for this word; m_last = !latched_mode.
  - If latched_mode=0 and word[7:0]≠0, increment pad_err_count (saturating).
  - Next state is EMIT_HI.
  - Changing mode_pair mid-word does not affect the current word.
- Transitions:
  - IDLE: load if FIFO non-empty; otherwise stay.
  - EMIT_HI, on handshake:
    - If latched_mode=1: m_data = word[7:0], m_last = 1, go to EMIT_LO.
    - Otherwise, if FIFO non-empty: load again back-to-back.
    - Otherwise: m_valid = 0, go to IDLE.
  - EMIT_LO, on handshake: load if FIFO non-empty; otherwise m_valid = 0, go to IDLE.
- Throughput and latency:
  - Throughput is one byte per cycle with m_ready held high; there are no bubbles between words.
  - Latency: a word accepted at edge E0 into an empty, idle block gives m_valid=1 after edge E0+1.
- byte_count increments once per m handshake and wraps 16'hFFFF→0.
- Flush:
  - Empties the FIFO, forces m_valid=0 and IDLE, and keeps both counters.
  - Takes priority over a push in the same cycle; that word is dropped.
  - s_ready stays 1 during flush.

Decomposition:
- Package test_module_unpacker_pkg:
  - State enum (IDLE/EMIT_HI/EMIT_LO).
  - BYTE_W/TAG_W defaults.
  - Counter widths.
  - Constant PAD_BYTE = 8'h00.
- Sub-module test_module_unpacker_fifo:
  - Synchronous DEPTH×(TAG_W+WORD_W) FIFO.
  - Pointers carry a wrap bit for the full/empty decision.
  - Ports: push, pop, full, empty, head.
- Top-level contents: FSM, output register, counters.

Test Plan:
- Reset, then push s_data=16'hA5_3C, s_tag=4'h7, mode_pair=1, m_ready=1:
  - Bytes A5 (m_last=0) then 3C (m_last=1), both with m_tag=7.
  - byte_count=2, pad_err_count=0.
- mode_pair=0, push 16'h1200 then 16'h3401:
  - Bytes 12 then 34, each with m_last=1.
  - pad_err_count=1.
- m_ready=0, push DEPTH+1 words:
  - s_ready drops after the FIFO fills; m_data holds its first byte throughout.
  - Raise m_ready: all 2×(DEPTH+1) bytes in order, back-to-back.
- Stream 32768 pair-mode words:
  - byte_count wraps to 0.
- Feed 300 bad-pad words in hi-only mode:
  - pad_err_count saturates at 255.
- Assert flush during EMIT_LO with 2 words queued:
  - Next cycle m_valid=0, busy=0, counters unchanged.
  - A later push delivers its bytes correctly.
- Drop reset_n mid-stream:
  - All outputs zero immediately.
  - Post-reset traffic is clean.
